// File: rtl/nvio3_alloc_pkg.sv
// Shared types and sizing for the IQ/ROB dispatch allocation controller.
package nvio3_alloc_pkg;

  localparam int unsigned QENTRIES    = 8;
  localparam int unsigned QSLOTS      = 2;
  localparam int unsigned RENTRIES    = 16;
  localparam int unsigned RECOVER_CYC = 2;

  localparam int unsigned IQ_CNTW  = $clog2(QENTRIES + 1);
  localparam int unsigned ROB_CNTW = $clog2(RENTRIES + 1);

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2,
    DRAIN   = 2'd3
  } alloc_state_t;

endpackage

// File: rtl/alloc_grant.sv
// In-order dispatch grant: a slot is granted only while every older slot was
// valid and granted and the cumulative IQ/ROB need still fits the free counts.
module alloc_grant #(
  parameter int unsigned SLOTS = 2,
  parameter int unsigned IW    = 4,
  parameter int unsigned RW    = 5
) (
  input  logic             en,
  input  logic [SLOTS-1:0] fetch_valid,
  input  logic [SLOTS-1:0] fetch_noiq,
  input  logic [IW-1:0]    iq_free,
  input  logic [RW-1:0]    rob_free,
  output logic [2:0]       queued_cnt,
  output logic [2:0]       rqueued_cnt,
  output logic [SLOTS-1:0] granted
);

  int unsigned need_i;
  int unsigned need_r;
  int unsigned slot_i;
  logic        ok;

  always_comb begin
    ok      = en;
    need_i  = 0;
    need_r  = 0;
    slot_i  = 0;
    granted = '0;
    for (int k = 0; k < int'(SLOTS); k++) begin
      slot_i = fetch_noiq[k] ? 32'd0 : 32'd1;
      ok = ok && fetch_valid[k]
              && ((need_r + 32'd1) <= 32'(rob_free))
              && ((need_i + slot_i) <= 32'(iq_free));
      if (ok) begin
        granted[k] = 1'b1;
        need_r     = need_r + 32'd1;
        need_i     = need_i + slot_i;
      end
    end
    queued_cnt  = 3'(need_i);
    rqueued_cnt = 3'(need_r);
  end

endmodule

// File: rtl/iq_alloc_ctrl.sv
// Dispatch allocation controller: grants fetched instructions into the IQ/ROB,
// tracks occupancy, and sequences branch-miss recovery and exception drain.
module iq_alloc_ctrl
  import nvio3_alloc_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [QSLOTS-1:0]   fetch_valid,
  input  logic [QSLOTS-1:0]   fetch_noiq,
  input  logic [2:0]          iq_release_cnt,
  input  logic [2:0]          rob_commit_cnt,
  input  logic                branchmiss,
  input  logic [IQ_CNTW-1:0]  iq_stomp_cnt,
  input  logic [ROB_CNTW-1:0] rob_stomp_cnt,
  input  logic                drain_req,
  output logic [2:0]          queuedCnt,
  output logic [2:0]          rqueuedCnt,
  output logic                fetch_stall,
  output logic [IQ_CNTW-1:0]  iq_free,
  output logic [ROB_CNTW-1:0] rob_free,
  output logic                drain_done,
  output logic                err,
  output logic [1:0]          state
);

  localparam int unsigned IQS  = IQ_CNTW + 2;
  localparam int unsigned ROBS = ROB_CNTW + 2;
  localparam int unsigned RCW  = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

  alloc_state_t        state_q, state_d;
  logic [RCW-1:0]      rcnt_q, rcnt_d;
  logic [IQ_CNTW-1:0]  iq_count, iq_next;
  logic [ROB_CNTW-1:0] rob_count, rob_next;
  logic                done_d;
  logic                iq_bad, rob_bad;
  logic signed [IQS-1:0]  iq_sum;
  logic signed [ROBS-1:0] rob_sum;
  logic [QSLOTS-1:0]   granted;
  logic                grant_en;

  assign grant_en = (state_q == RUN) && !branchmiss && !rst_i;

  alloc_grant #(
    .SLOTS (QSLOTS),
    .IW    (IQ_CNTW),
    .RW    (ROB_CNTW)
  ) u_grant (
    .en          (grant_en),
    .fetch_valid (fetch_valid),
    .fetch_noiq  (fetch_noiq),
    .iq_free     (iq_free),
    .rob_free    (rob_free),
    .queued_cnt  (queuedCnt),
    .rqueued_cnt (rqueuedCnt),
    .granted     (granted)
  );

  assign fetch_stall = rst_i || (|(fetch_valid & ~granted));
  assign iq_free     = IQ_CNTW'(QENTRIES) - iq_count;
  assign rob_free    = ROB_CNTW'(RENTRIES) - rob_count;
  assign state       = state_q;

  // Signed occupancy update with clamping; any clamp marks an accounting error.
  always_comb begin
    iq_bad  = 1'b0;
    rob_bad = 1'b0;
    iq_sum  = IQS'(iq_count) + IQS'(queuedCnt) - IQS'(iq_release_cnt)
            - (branchmiss ? IQS'(iq_stomp_cnt) : IQS'(0));
    rob_sum = ROBS'(rob_count) + ROBS'(rqueuedCnt) - ROBS'(rob_commit_cnt)
            - (branchmiss ? ROBS'(rob_stomp_cnt) : ROBS'(0));
    iq_next  = iq_sum[IQ_CNTW-1:0];
    rob_next = rob_sum[ROB_CNTW-1:0];
    if (iq_sum[IQS-1]) begin
      iq_next = '0;
      iq_bad  = 1'b1;
    end else if (iq_sum[IQS-2:0] > (IQS-1)'(QENTRIES)) begin
      iq_next = IQ_CNTW'(QENTRIES);
      iq_bad  = 1'b1;
    end
    if (rob_sum[ROBS-1]) begin
      rob_next = '0;
      rob_bad  = 1'b1;
    end else if (rob_sum[ROBS-2:0] > (ROBS-1)'(RENTRIES)) begin
      rob_next = ROB_CNTW'(RENTRIES);
      rob_bad  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      INIT: state_d = RUN;
      RUN: begin
        if (branchmiss) begin
          state_d = RECOVER;
          rcnt_d  = RCW'(RECOVER_CYC - 1);
        end else if (drain_req) begin
          state_d = DRAIN;
        end
      end
      RECOVER: begin
        if (branchmiss) begin
          rcnt_d = RCW'(RECOVER_CYC - 1);
        end else if (rcnt_q == '0) begin
          state_d = drain_req ? DRAIN : RUN;
        end else begin
          rcnt_d = rcnt_q - RCW'(1);
        end
      end
      DRAIN: begin
        // A miss during drain keeps draining; the ROB is still being stomped.
        if (!branchmiss && rob_next == '0) begin
          done_d  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= INIT;
      rcnt_q     <= '0;
      iq_count   <= '0;
      rob_count  <= '0;
      err        <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      iq_count   <= iq_next;
      rob_count  <= rob_next;
      err        <= err | iq_bad | rob_bad;
      drain_done <= done_d;
    end
  end

endmodule
